mem_1r1w_rmw_banked: RTL and testbench

- Parametrised 1-read/1-write masked memory built from single-bank, unmasked 1r1w SRAM macros.
- Partial-mask writes are emulated with an internal read-modify-write (RMW) sequence that borrows the read port.
- Depth is banked across ceil(DEPTH/BANK_DEPTH) macros.
- Sits between Chisel-lowered memory ports and the vendor macros wherever the macro has no bit-write mask.

---
 rtl/mem_rmw_pkg.sv | 31 +++
 rtl/mem_1r1w_rmw_banked_if.sv | 27 ++
 rtl/mem_rmw_bank.sv | 36 +++
 rtl/mem_1r1w_rmw_banked.sv | 133 +++++++++++++
 tb/tb_mem_1r1w_rmw_banked.sv | 180 ++++++++++++++++++
 5 files changed

// File: rtl/mem_rmw_pkg.sv
// Shared constants and helpers for the banked 1r1w memory with read-modify-write masking.
package mem_rmw_pkg;

  localparam logic [0:0] StIdle  = 1'b0;
  localparam logic [0:0] StMerge = 1'b1;

  // Upper bound on word width handled by expand_mask.
  localparam int unsigned MaxWidth = 1024;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    res = 0;
    while ((64'd1 << res) < 64'(value)) res++;
    return res;
  endfunction

  function automatic int unsigned ceil_div(input int unsigned num, input int unsigned den);
    return (num + den - 1) / den;
  endfunction

  function automatic logic [MaxWidth-1:0] expand_mask(input logic [MaxWidth-1:0] lanes,
                                                      input int unsigned gran);
    logic [MaxWidth-1:0] bits;
    bits = '0;
    if (gran != 0) begin
      for (int unsigned i = 0; i < MaxWidth; i++) bits[i] = lanes[i / gran];
    end
    return bits;
  endfunction

endpackage

// File: rtl/mem_1r1w_rmw_banked_if.sv
// Read/write port bundle for mem_1r1w_rmw_banked.
interface mem_1r1w_rmw_banked_if #(
  parameter int unsigned AW    = 6,
  parameter int unsigned WIDTH = 64,
  parameter int unsigned MW    = 8
);
  logic [AW-1:0]    R0_addr;
  logic             R0_en;
  logic             R0_ready;
  logic             R0_valid;
  logic [WIDTH-1:0] R0_data;
  logic [AW-1:0]    W0_addr;
  logic             W0_en;
  logic             W0_ready;
  logic [WIDTH-1:0] W0_data;
  logic [MW-1:0]    W0_mask;

  modport master (
    output R0_addr, R0_en, W0_addr, W0_en, W0_data, W0_mask,
    input  R0_ready, R0_valid, R0_data, W0_ready
  );

  modport slave (
    input  R0_addr, R0_en, W0_addr, W0_en, W0_data, W0_mask,
    output R0_ready, R0_valid, R0_data, W0_ready
  );
endinterface

// File: rtl/mem_rmw_bank.sv
// One unmasked 1r1w macro: active-high requests become active-low selects, address sliced in-bank.
module mem_rmw_bank
  import mem_rmw_pkg::*;
#(
  parameter int unsigned AW         = 6,
  parameter int unsigned WIDTH      = 64,
  parameter int unsigned BANK_DEPTH = 32,
  parameter int unsigned WORDS      = 32
) (
  input  logic             clk,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data
);
  localparam int unsigned WAW = (WORDS > 1) ? clog2(WORDS) : 1;

  logic             rd_cs_n, wr_cs_n;
  logic [WAW-1:0]   rd_idx, wr_idx;
  logic [WIDTH-1:0] mem_q [WORDS];

  assign rd_cs_n = ~rd_en;
  assign wr_cs_n = ~wr_en;
  // Only in-range addresses are ever enabled, so truncating to the populated depth is safe.
  assign rd_idx  = WAW'(32'(rd_addr) % BANK_DEPTH);
  assign wr_idx  = WAW'(32'(wr_addr) % BANK_DEPTH);

  // Read-before-write macro model; same-address collisions are resolved upstream.
  always_ff @(posedge clk) begin
    if (!wr_cs_n) mem_q[wr_idx] <= wr_data;
    if (!rd_cs_n) rd_data <= mem_q[rd_idx];
  end

endmodule

// File: rtl/mem_1r1w_rmw_banked.sv
// Masked 1r1w memory over banked unmasked macros; partial-mask writes become a two-cycle RMW.
module mem_1r1w_rmw_banked
  import mem_rmw_pkg::*;
#(
  parameter int unsigned DEPTH      = 48,
  parameter int unsigned WIDTH      = 64,
  parameter int unsigned BANK_DEPTH = 32,
  parameter int unsigned MASK_GRAN  = 8
) (
  input logic                  clk,
  input logic                  rst_n,
  mem_1r1w_rmw_banked_if.slave bus
);
  localparam int unsigned AW     = clog2(DEPTH);
  localparam int unsigned NBANKS = ceil_div(DEPTH, BANK_DEPTH);
  localparam int unsigned BW     = (NBANKS > 1) ? clog2(NBANKS) : 1;
  localparam int unsigned MW     = WIDTH / MASK_GRAN;

  function automatic logic [BW-1:0] bank_of(input logic [AW-1:0] addr);
    return BW'(32'(addr) / BANK_DEPTH);
  endfunction

  function automatic logic in_range(input logic [AW-1:0] addr);
    return 32'(addr) < DEPTH;
  endfunction

  logic [0:0]       state_q, state_d;
  logic [AW-1:0]    hold_addr_q;
  logic [WIDTH-1:0] hold_data_q;
  logic [MW-1:0]    hold_mask_q;
  logic             rvalid_q, roor_q, fwd_q;
  logic [BW-1:0]    rbank_q;
  logic [WIDTH-1:0] fwd_data_q;

  logic             rmw_rd, capture, r_acc, rd_en, wr_en, fwd_hit;
  logic [AW-1:0]    rd_addr, wr_addr;
  logic [WIDTH-1:0] wr_data, merged, bitmask;
  logic [WIDTH-1:0] bank_rdata [NBANKS];

  assign bitmask = WIDTH'(expand_mask(MaxWidth'(hold_mask_q), MASK_GRAN));
  assign merged  = (bank_rdata[bank_of(hold_addr_q)] & ~bitmask) | (hold_data_q & bitmask);

  always_comb begin
    state_d      = state_q;
    bus.W0_ready = 1'b0;
    bus.R0_ready = 1'b1;
    rmw_rd       = 1'b0;
    capture      = 1'b0;
    wr_en        = 1'b0;
    wr_addr      = hold_addr_q;
    wr_data      = merged;
    case (state_q)
      StIdle: begin
        bus.W0_ready = 1'b1;
        if (bus.W0_en) begin
          if (!(&bus.W0_mask) && (|bus.W0_mask)) begin
            // The RMW read takes the read port this cycle.
            bus.R0_ready = 1'b0;
            rmw_rd       = 1'b1;
            capture      = 1'b1;
            state_d      = StMerge;
          end else begin
            wr_en   = (&bus.W0_mask) && in_range(bus.W0_addr);
            wr_addr = bus.W0_addr;
            wr_data = bus.W0_data;
          end
        end
      end
      StMerge: begin
        wr_en   = in_range(hold_addr_q);
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign r_acc   = bus.R0_en && bus.R0_ready;
  assign rd_addr = rmw_rd ? bus.W0_addr : bus.R0_addr;
  assign rd_en   = (rmw_rd || r_acc) && in_range(rd_addr);
  assign fwd_hit = wr_en && (bus.R0_addr == wr_addr);

  for (genvar b = 0; b < NBANKS; b++) begin : g_bank
    localparam int unsigned Words = (b == NBANKS - 1) ? DEPTH - b * BANK_DEPTH : BANK_DEPTH;
    mem_rmw_bank #(
      .AW        (AW),
      .WIDTH     (WIDTH),
      .BANK_DEPTH(BANK_DEPTH),
      .WORDS     (Words)
    ) u_bank (
      .clk    (clk),
      .rd_en  (rd_en && (bank_of(rd_addr) == BW'(b))),
      .rd_addr(rd_addr),
      .wr_en  (wr_en && (bank_of(wr_addr) == BW'(b))),
      .wr_addr(wr_addr),
      .wr_data(wr_data),
      .rd_data(bank_rdata[b])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      hold_addr_q <= '0;
      hold_data_q <= '0;
      hold_mask_q <= '0;
      rvalid_q    <= 1'b0;
      roor_q      <= 1'b0;
      fwd_q       <= 1'b0;
      rbank_q     <= '0;
      fwd_data_q  <= '0;
    end else begin
      state_q  <= state_d;
      rvalid_q <= r_acc;
      if (capture) begin
        hold_addr_q <= bus.W0_addr;
        hold_data_q <= bus.W0_data;
        hold_mask_q <= bus.W0_mask;
      end
      if (r_acc) begin
        rbank_q    <= bank_of(bus.R0_addr);
        roor_q     <= !in_range(bus.R0_addr);
        fwd_q      <= fwd_hit;
        fwd_data_q <= wr_data;
      end
    end
  end

  assign bus.R0_valid = rvalid_q;
  assign bus.R0_data  = !rvalid_q ? '0 :
                        roor_q    ? '0 :
                        fwd_q     ? fwd_data_q : bank_rdata[rbank_q];

endmodule

// File: tb/tb_mem_1r1w_rmw_banked.sv
// Directed bench for mem_1r1w_rmw_banked with hand-computed expectations.
module tb_mem_1r1w_rmw_banked;
  localparam int unsigned Depth     = 48;
  localparam int unsigned Width     = 64;
  localparam int unsigned BankDepth = 32;
  localparam int unsigned MaskGran  = 8;
  localparam int unsigned Aw        = 6;
  localparam int unsigned Mw        = 8;

  logic clk;
  logic rst_n;
  int unsigned n_checks;
  int unsigned n_errors;

  mem_1r1w_rmw_banked_if #(.AW(Aw), .WIDTH(Width), .MW(Mw)) bus_if ();

  mem_1r1w_rmw_banked #(
    .DEPTH     (Depth),
    .WIDTH     (Width),
    .BANK_DEPTH(BankDepth),
    .MASK_GRAN (MaskGran)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%h, expected 0x%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_write(input logic [Aw-1:0] addr, input logic [63:0] data,
                             input logic [Mw-1:0] mask);
    bus_if.W0_en   = 1'b1;
    bus_if.W0_addr = addr;
    bus_if.W0_data = data;
    bus_if.W0_mask = mask;
  endtask

  task automatic drive_read(input logic [Aw-1:0] addr);
    bus_if.R0_en   = 1'b1;
    bus_if.R0_addr = addr;
  endtask

  initial begin
    n_checks       = 0;
    n_errors       = 0;
    rst_n          = 1'b0;
    bus_if.R0_en   = 1'b0;
    bus_if.R0_addr = '0;
    bus_if.W0_en   = 1'b0;
    bus_if.W0_addr = '0;
    bus_if.W0_data = '0;
    bus_if.W0_mask = '0;

    #3;
    check("reset_r0_valid", 64'(bus_if.R0_valid), 64'd0);
    check("reset_r0_data", bus_if.R0_data, 64'd0);
    check("reset_w0_ready", 64'(bus_if.W0_ready), 64'd1);
    check("reset_r0_ready", 64'(bus_if.R0_ready), 64'd1);
    step();
    rst_n = 1'b1;
    step();

    // Full write then read, one-cycle latency.
    drive_write(6'd5, 64'h1111_2222_3333_4444, 8'hFF);
    #1;
    check("full_write_r0_ready", 64'(bus_if.R0_ready), 64'd1);
    step();
    bus_if.W0_en = 1'b0;
    drive_read(6'd5);
    step();
    check("full_read_valid", 64'(bus_if.R0_valid), 64'd1);
    check("full_read_data", bus_if.R0_data, 64'h1111_2222_3333_4444);
    bus_if.R0_en = 1'b0;
    step();
    check("idle_valid_low", 64'(bus_if.R0_valid), 64'd0);
    check("idle_data_zero", bus_if.R0_data, 64'd0);

    // All-zero mask leaves the word untouched.
    drive_write(6'd5, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00);
    step();
    bus_if.W0_en = 1'b0;
    drive_read(6'd5);
    step();
    check("zero_mask_nochange", bus_if.R0_data, 64'h1111_2222_3333_4444);
    bus_if.R0_en = 1'b0;

    // Partial write to bank 1 with a read held on the same address.
    drive_write(6'd40, 64'hAAAA_AAAA_AAAA_AAAA, 8'hFF);
    step();
    drive_write(6'd40, 64'h5555_5555_5555_5555, 8'h0F);
    drive_read(6'd40);
    #1;
    check("rmw_r0_ready_low", 64'(bus_if.R0_ready), 64'd0);
    step();
    bus_if.W0_en = 1'b0;
    #1;
    check("rmw_user_read_blocked", 64'(bus_if.R0_valid), 64'd0);
    check("merge_w0_ready_low", 64'(bus_if.W0_ready), 64'd0);
    check("merge_r0_ready_high", 64'(bus_if.R0_ready), 64'd1);
    step();
    check("merge_fwd_valid", 64'(bus_if.R0_valid), 64'd1);
    check("merge_fwd_data", bus_if.R0_data, 64'hAAAA_AAAA_5555_5555);
    step();
    check("merged_stored", bus_if.R0_data, 64'hAAAA_AAAA_5555_5555);
    bus_if.R0_en = 1'b0;

    // Same-cycle write/read at the last bank-0 word, then bank boundary.
    drive_write(6'd32, 64'h3232_3232_3232_3232, 8'hFF);
    step();
    drive_write(6'd31, 64'hDEAD_BEEF_0000_0001, 8'hFF);
    drive_read(6'd31);
    step();
    bus_if.W0_en = 1'b0;
    check("collision_fwd", bus_if.R0_data, 64'hDEAD_BEEF_0000_0001);
    drive_read(6'd32);
    step();
    check("bank1_boundary", bus_if.R0_data, 64'h3232_3232_3232_3232);
    drive_read(6'd31);
    step();
    check("bank0_last_word", bus_if.R0_data, 64'hDEAD_BEEF_0000_0001);
    bus_if.R0_en = 1'b0;

    // Out-of-range write must not alias into bank 1; out-of-range read returns zero.
    drive_write(6'd34, 64'h3434_3434_3434_3434, 8'hFF);
    step();
    drive_write(6'd50, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
    #1;
    check("oor_write_ready", 64'(bus_if.W0_ready), 64'd1);
    step();
    bus_if.W0_en = 1'b0;
    drive_read(6'd50);
    step();
    check("oor_read_valid", 64'(bus_if.R0_valid), 64'd1);
    check("oor_read_data", bus_if.R0_data, 64'd0);
    drive_read(6'd34);
    step();
    check("oor_no_alias", bus_if.R0_data, 64'h3434_3434_3434_3434);
    bus_if.R0_en = 1'b0;

    // Reset during MERGE drops the pending write.
    drive_write(6'd3, 64'd0, 8'hFF);
    step();
    drive_write(6'd3, 64'h0000_0000_0000_0077, 8'h01);
    step();
    bus_if.W0_en = 1'b0;
    #1;
    check("pre_reset_merge", 64'(bus_if.W0_ready), 64'd0);
    rst_n = 1'b0;
    #1;
    check("rst_r0_valid", 64'(bus_if.R0_valid), 64'd0);
    check("rst_w0_ready", 64'(bus_if.W0_ready), 64'd1);
    step();
    rst_n = 1'b1;
    step();
    drive_read(6'd3);
    step();
    check("rst_drop_valid", 64'(bus_if.R0_valid), 64'd1);
    check("rst_drop_merge", bus_if.R0_data, 64'd0);
    bus_if.R0_en = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
